// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI-Stream transmit packer.
//   tx_state_e : packer FSM states (ACCUM gathers bytes, FLUSH emits the tail
//                beat of a packet whose last chunk overflowed one beat).
//   keep_mask  : contiguous byte-qualifier mask with the lowest n bits set.
//                The result is MAX_BYTES wide; callers size-cast it to their
//                own byte count.
// -----------------------------------------------------------------------------
package axi_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      FLUSH = 1'b1
   } tx_state_e;

   localparam int unsigned MAX_BYTES = 128;

   function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned n);
      logic [MAX_BYTES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Registered AXI-Stream output slice. A beat offered on load is captured and
// presented on the t* outputs on the next cycle; the beat holds unchanged
// while tready is low.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture load_data/keep/last (only while ready is high)
//   load_data    : beat data
//   load_keep    : beat byte qualifiers
//   load_last    : beat ends a packet
//   ready        : slice can take a beat this cycle (empty or draining)
//   tvalid/tdata/tkeep/tlast : AXI-Stream master outputs
//   tready       : downstream ready
// -----------------------------------------------------------------------------
module axis_out_reg #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [DATA_WIDTH-1:0]   load_data,
   input  logic [DATA_WIDTH/8-1:0] load_keep,
   input  logic                    load_last,
   output logic                    ready,
   output logic                    tvalid,
   output logic [DATA_WIDTH-1:0]   tdata,
   output logic [DATA_WIDTH/8-1:0] tkeep,
   output logic                    tlast,
   input  logic                    tready
);

   // The slice can be refilled in the same cycle its current beat drains,
   // which is what lets full beats stream at one per cycle.
   assign ready = !tvalid || tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tvalid <= 1'b0;
         tdata  <= '0;
         tkeep  <= '0;
         tlast  <= 1'b0;
      end else if (load) begin
         tvalid <= 1'b1;
         tdata  <= load_data;
         tkeep  <= load_keep;
         tlast  <= load_last;
      end else if (tready) begin
         tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_tx.sv
// -----------------------------------------------------------------------------
// axi_tx
// Packs variable-length byte chunks into full-width AXI-Stream beats.
// Accepted bytes are appended to a residue of fewer than B bytes; whenever a
// full beat's worth is available it is emitted, and the final beat of a packet
// carries whatever remains with tlast set. A last chunk that overflows one
// beat emits a full beat first and the tail from FLUSH on the next slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid/in_data/in_count/in_last/in_ready : chunk input handshake;
//                valid bytes occupy lanes 0..in_count-1
//   tvalid/tdata/tkeep/tlast/tready : AXI-Stream output
//   pkt_count  : number of tlast handshakes since reset (wraps)
// -----------------------------------------------------------------------------
module axi_tx
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   input  logic [DATA_WIDTH-1:0]              in_data,
   input  logic [$clog2(DATA_WIDTH/8+1)-1:0]  in_count,
   input  logic                               in_last,
   output logic                               in_ready,
   output logic                               tvalid,
   output logic [DATA_WIDTH-1:0]              tdata,
   output logic [DATA_WIDTH/8-1:0]            tkeep,
   output logic                               tlast,
   input  logic                               tready,
   output logic [31:0]                        pkt_count
);

   localparam int B  = DATA_WIDTH / 8;
   localparam int CW = $clog2(B + 1);
   localparam int TW = CW + 1;          // holds residue + chunk, up to 2B-1

   tx_state_e               state, state_nxt;
   logic [DATA_WIDTH-1:0]   res_data, res_data_nxt;
   logic [CW-1:0]           res_cnt, res_cnt_nxt;

   logic                    slice_ready;
   logic                    accept;
   logic                    load;
   logic [DATA_WIDTH-1:0]   load_data;
   logic [B-1:0]            load_keep;
   logic                    load_last;

   logic [DATA_WIDTH-1:0]   in_masked;
   logic [2*DATA_WIDTH-1:0] merged;
   logic [TW-1:0]           total;

   // rst_n gates in_ready so the producer sees no acceptance during reset.
   assign in_ready = rst_n && (state == ACCUM) && slice_ready;
   assign accept   = in_valid && in_ready;

   // Bytes above in_count are zeroed so the residue never carries stale lanes
   // into a later beat, and a null beat comes out with tdata all zero.
   always_comb begin
      in_masked = '0;
      for (int i = 0; i < B; i++) begin
         if (i < 32'(in_count)) begin
            in_masked[8*i +: 8] = in_data[8*i +: 8];
         end
      end
   end

   // Residue sits in the low lanes; the new chunk lands right after it.
   assign merged = {{DATA_WIDTH{1'b0}}, res_data}
                 | ({{DATA_WIDTH{1'b0}}, in_masked} << {res_cnt, 3'b000});
   assign total  = TW'(res_cnt) + TW'(in_count);

   always_comb begin
      state_nxt    = state;
      res_data_nxt = res_data;
      res_cnt_nxt  = res_cnt;
      load         = 1'b0;
      load_data    = '0;
      load_keep    = '0;
      load_last    = 1'b0;

      case (state)
         ACCUM: begin
            if (accept) begin
               if ((total > TW'(B)) || ((total == TW'(B)) && !in_last)) begin
                  // Full beat goes out now; overflow bytes stay behind.
                  load         = 1'b1;
                  load_data    = merged[DATA_WIDTH-1:0];
                  load_keep    = '1;
                  load_last    = 1'b0;
                  res_data_nxt = merged[2*DATA_WIDTH-1:DATA_WIDTH];
                  res_cnt_nxt  = CW'(total - TW'(B));
                  if (in_last) begin
                     state_nxt = FLUSH;
                  end
               end else if (in_last) begin
                  // Whole packet remainder fits one beat (possibly null).
                  load         = 1'b1;
                  load_data    = merged[DATA_WIDTH-1:0];
                  load_keep    = B'(keep_mask(32'(total)));
                  load_last    = 1'b1;
                  res_data_nxt = '0;
                  res_cnt_nxt  = '0;
               end else begin
                  res_data_nxt = merged[DATA_WIDTH-1:0];
                  res_cnt_nxt  = CW'(total);
               end
            end
         end

         FLUSH: begin
            // The tail is handed to the output slice as soon as it has room;
            // the packer returns to ACCUM at that hand-off, so input is held
            // off for exactly one slot.
            if (slice_ready) begin
               load         = 1'b1;
               load_data    = res_data;
               load_keep    = B'(keep_mask(32'(res_cnt)));
               load_last    = 1'b1;
               res_data_nxt = '0;
               res_cnt_nxt  = '0;
               state_nxt    = ACCUM;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ACCUM;
         res_data <= '0;
         res_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         res_data <= res_data_nxt;
         res_cnt  <= res_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count <= '0;
      end else if (tvalid && tready && tlast) begin
         pkt_count <= pkt_count + 32'd1;
      end
   end

   axis_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (load_data),
      .load_keep (load_keep),
      .load_last (load_last),
      .ready     (slice_ready),
      .tvalid    (tvalid),
      .tdata     (tdata),
      .tkeep     (tkeep),
      .tlast     (tlast),
      .tready    (tready)
   );

endmodule

// File: tb/tb_axi_tx.sv
// -----------------------------------------------------------------------------
// tb_axi_tx
// Directed and randomized stimulus for axi_tx (DATA_WIDTH=64). Expected beats
// come from a byte-queue model of the packing rules; every output handshake is
// matched against it, and stalled beats are checked for stability.
// -----------------------------------------------------------------------------
module tb_axi_tx;

   localparam int DW = 64;
   localparam int B  = DW / 8;
   localparam int CW = $clog2(B + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_count;
   logic          in_last;
   logic          in_ready;
   logic          tvalid;
   logic [DW-1:0] tdata;
   logic [B-1:0]  tkeep;
   logic          tlast;
   logic          tready = 1'b1;
   logic [31:0]   pkt_count;

   axi_tx #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_count  (in_count),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .tvalid    (tvalid),
      .tdata     (tdata),
      .tkeep     (tkeep),
      .tlast     (tlast),
      .tready    (tready),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [B-1:0]  keep;
      logic          last;
   } beat_t;

   int          vectors = 0;
   int          miscompares = 0;
   beat_t       exp_q[$];
   logic [7:0]  pend[$];
   int          model_pkts = 0;
   int          cyc = 0;
   int          hs_cyc[$];
   bit          rand_bp = 1'b0;
   bit          tready_force = 1'b1;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      tready = rand_bp ? ($urandom_range(0, 3) != 0) : tready_force;
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: bytes of the current packet in arrival order.
   task automatic emit(input int n, input bit last);
      beat_t b;
      b.data = '0;
      b.keep = '0;
      b.last = last;
      for (int i = 0; i < n; i++) begin
         b.data[8*i +: 8] = pend.pop_front();
         b.keep[i] = 1'b1;
      end
      exp_q.push_back(b);
   endtask

   task automatic model_accept(input logic [DW-1:0] d, input int cnt, input bit last);
      for (int i = 0; i < cnt; i++) pend.push_back(d[8*i +: 8]);
      if (last) begin
         while (pend.size() > B) emit(B, 1'b0);
         emit(pend.size(), 1'b1);
      end else begin
         while (pend.size() >= B) emit(B, 1'b0);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int cnt, input bit last);
      logic [DW-1:0] d;
      int waited;
      d = {$urandom, $urandom};
      in_valid = 1'b1;
      in_data  = d;
      in_count = CW'(cnt);
      in_last  = last;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      model_accept(d, cnt, last);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
      in_count = '0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tvalid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_beats_left", 64'(exp_q.size()), 64'd0);
      check("drain_tvalid", 64'(tvalid), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor / scoreboard.
   logic          stall_prev = 1'b0;
   logic [DW-1:0] hold_data;
   logic [B-1:0]  hold_keep;
   logic          hold_last;

   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         stall_prev = 1'b0;
         model_pkts = 0;
      end else begin
         if (in_valid) check("in_count_le_B", 64'(in_count <= CW'(B)), 64'd1);
         if (stall_prev) begin
            check("hold_tvalid", 64'(tvalid), 64'd1);
            check("hold_tdata", tdata, hold_data);
            check("hold_tkeep", 64'(tkeep), 64'(hold_keep));
            check("hold_tlast", 64'(tlast), 64'(hold_last));
         end
         if (tvalid && tready) begin
            hs_cyc.push_back(cyc);
            check("pkt_count_run", 64'(pkt_count), 64'(model_pkts));
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check("beat_tdata", tdata, e.data);
               check("beat_tkeep", 64'(tkeep), 64'(e.keep));
               check("beat_tlast", 64'(tlast), 64'(e.last));
               if (e.last) model_pkts++;
            end
         end
         stall_prev = tvalid && !tready;
         hold_data  = tdata;
         hold_keep  = tkeep;
         hold_last  = tlast;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      beat_t e;
      in_valid = 1'b0;
      in_data  = '0;
      in_count = '0;
      in_last  = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_tdata", tdata, 64'd0);
      check("rst_tkeep", 64'(tkeep), 64'd0);
      check("rst_tlast", 64'(tlast), 64'd0);
      check("rst_pkt_count", 64'(pkt_count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_release", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // 3+3+3+2 with last: full beat then 3-byte tail
      send(3, 1'b0);
      send(3, 1'b0);
      send(3, 1'b0);
      send(2, 1'b1);
      drain();
      check("pkt_count_3332", 64'(pkt_count), 64'd1);

      // 5 then 7 with last: full beat, then FLUSH tail of 4 bytes
      send(5, 1'b0);
      send(7, 1'b1);
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'd0);
      check("flush_full_tkeep", 64'(tkeep), 64'hFF);
      check("flush_full_tlast", 64'(tlast), 64'd0);
      @(negedge clk);
      check("flush_done_in_ready", 64'(in_ready), 64'd1);
      check("flush_tail_tkeep", 64'(tkeep), 64'h0F);
      check("flush_tail_tlast", 64'(tlast), 64'd1);
      @(posedge clk);
      #1;
      drain();
      check("pkt_count_57", 64'(pkt_count), 64'd2);

      // Backpressure: beat held for 4 cycles, then transfers
      tready_force = 1'b0;
      send(8, 1'b0);
      e = exp_q[0];
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_tvalid", 64'(tvalid), 64'd1);
         check("bp_tdata", tdata, e.data);
         check("bp_tkeep", 64'(tkeep), 64'hFF);
         check("bp_tlast", 64'(tlast), 64'd0);
      end
      @(posedge clk);
      #1 tready_force = 1'b1;
      @(negedge clk);
      check("bp_xfer_tvalid", 64'(tvalid), 64'd1);
      check("bp_xfer_tready", 64'(tready), 64'd1);
      @(negedge clk);
      check("bp_after_tvalid", 64'(tvalid), 64'd0);
      @(posedge clk);
      #1;
      send(0, 1'b1);
      drain();
      check("pkt_count_bp", 64'(pkt_count), 64'd3);

      // Ten 8-byte chunks back to back: no bubbles
      hs_cyc.delete();
      for (int i = 0; i < 10; i++) send(8, i == 9);
      drain();
      check("b2b_beats", 64'(hs_cyc.size()), 64'd10);
      for (int i = 1; i < 10 && i < hs_cyc.size(); i++)
         check("b2b_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);
      check("pkt_count_b2b", 64'(pkt_count), 64'd4);

      // Null beat on empty residue
      send(0, 1'b1);
      @(negedge clk);
      check("null_tvalid", 64'(tvalid), 64'd1);
      check("null_tkeep", 64'(tkeep), 64'd0);
      check("null_tlast", 64'(tlast), 64'd1);
      check("null_tdata", tdata, 64'd0);
      @(posedge clk);
      #1;
      drain();
      check("pkt_count_null", 64'(pkt_count), 64'd5);

      // Reset mid-packet with residue and a stalled beat
      send(3, 1'b0);
      tready_force = 1'b0;
      send(8, 1'b0);
      @(negedge clk);
      check("mid_stalled_tvalid", 64'(tvalid), 64'd1);
      #1 rst_n = 1'b0;
      exp_q.delete();
      pend.delete();
      #1;
      check("mid_rst_tvalid", 64'(tvalid), 64'd0);
      check("mid_rst_tdata", tdata, 64'd0);
      check("mid_rst_tkeep", 64'(tkeep), 64'd0);
      check("mid_rst_tlast", 64'(tlast), 64'd0);
      check("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      tready_force = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(2, 1'b1);
      @(negedge clk);
      check("post_rst_tkeep", 64'(tkeep), 64'h03);
      check("post_rst_tdata_hi", 64'(tdata[DW-1:16]), 64'd0);
      @(posedge clk);
      #1;
      drain();
      check("pkt_count_post_rst", 64'(pkt_count), 64'd1);

      // Randomized chunks under random backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++)
         send($urandom_range(0, B), $urandom_range(0, 3) == 0);
      send($urandom_range(0, B), 1'b1);
      drain();
      rand_bp = 1'b0;
      @(posedge clk);
      #1;
      check("pkt_count_random", 64'(pkt_count), 64'(model_pkts));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
